// File: rtl/smart_lights_pkg.sv
`default_nettype none
// ============================================================================
// Module      : smart_lights_pkg
// Description : Shared definitions for the smart-lights zone controller:
//               zone state encoding, counter width helpers and the hold-time
//               derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package smart_lights_pkg;

  typedef enum logic [1:0] {
    ZS_IDLE = 2'b00,
    ZS_WAIT = 2'b01,
    ZS_LIT  = 2'b10,
    ZS_HOLD = 2'b11
  } zone_state_t;

  // $clog2 clamped to at least 1 bit so degenerate sizes still give a
  // legal vector.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  // Bits needed to hold any value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return clog2_min1(max_val + 1);
  endfunction

  // Off-delay expressed in timebase ticks.
  function automatic int unsigned hold_ticks(input int unsigned sec,
                                             input int unsigned tick_hz);
    return sec * tick_hz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pir_debounce.sv
`default_nettype none
// ============================================================================
// Module      : pir_debounce
// Description : Two-flop synchroniser and tick-based debouncer for one
//               active-low PIR channel. The debounced level only changes
//               after the synchronised input has disagreed with it for
//               DEBOUNCE_TICKS consecutive ticks.
// Revision    : 1.0 - initial release
// Ports       :
//   clk       in  1  system clock
//   reset_n   in  1  asynchronous active-low reset
//   i_tick    in  1  one-cycle timebase strobe
//   i_pir_n   in  1  raw PIR input, active-low, asynchronous
//   o_motion  out 1  debounced motion, active-high
// ============================================================================
module pir_debounce
  import smart_lights_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_tick,
  input  logic i_pir_n,
  output logic o_motion
);

  localparam int unsigned c_CNT_W = cnt_width(DEBOUNCE_TICKS);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_motion;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_raw;

  assign w_raw    = ~r_sync2;
  assign o_motion = r_motion;

  // Synchroniser resets to the idle (high) level so releasing reset does
  // not look like a PIR edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_motion <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_pir_n;
      r_sync2 <= r_sync1;
      if (w_raw == r_motion) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        // The tick that would bring the count to DEBOUNCE_TICKS flips the
        // state instead of storing that value.
        if (r_cnt == c_CNT_W'(DEBOUNCE_TICKS - 1)) begin
          r_motion <= w_raw;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/smart_lights_zone_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : smart_lights_zone_ctrl
// Description : Multi-zone lighting controller. Debounces N PIR inputs, runs
//               a per-zone occupancy FSM with a retriggerable hold timer and
//               a round-robin arbiter that keeps at most MAX_ON zones lit.
// Revision    : 1.0 - initial release
// Ports       :
//   clk          in  1                  system clock
//   reset_n      in  1                  asynchronous active-low reset
//   i_pir_n      in  N_ZONES            raw PIR inputs, active-low
//   i_enable     in  1                  global lights enable
//   o_led_out    out N_ZONES            zone LEDs, active-high
//   o_waiting    out N_ZONES            zone has motion but no budget slot
//   o_lit_count  out clog2(N_ZONES+1)   number of zones currently lit
// ============================================================================
module smart_lights_zone_ctrl
  import smart_lights_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
  parameter int unsigned TICK_HZ        = 1000,
  parameter int unsigned N_ZONES        = 4,
  parameter int unsigned MAX_ON         = 2,
  parameter int unsigned HOLD_TIME_SEC  = 5,
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_ZONES-1:0]           i_pir_n,
  input  logic                         i_enable,
  output logic [N_ZONES-1:0]           o_led_out,
  output logic [N_ZONES-1:0]           o_waiting,
  output logic [$clog2(N_ZONES+1)-1:0] o_lit_count
);

  localparam int unsigned c_DIV        = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned c_PRE_W      = clog2_min1(c_DIV);
  localparam int unsigned c_HOLD_TICKS = hold_ticks(HOLD_TIME_SEC, TICK_HZ);
  localparam int unsigned c_HOLD_W     = cnt_width(c_HOLD_TICKS);
  localparam int unsigned c_PTR_W      = clog2_min1(N_ZONES);
  localparam int unsigned c_LIT_W      = $clog2(N_ZONES + 1);

  logic [c_PRE_W-1:0] r_presc;
  logic               w_tick;

  logic [N_ZONES-1:0] w_motion;
  logic [N_ZONES-1:0] w_lit;
  logic [N_ZONES-1:0] w_elig;
  logic [N_ZONES-1:0] w_grant;
  logic [c_PTR_W-1:0] r_rr_ptr;
  logic [c_PTR_W-1:0] w_rr_next;
  logic [c_LIT_W-1:0] w_lit_now;

  // --------------------------------------------------------------------------
  // Timebase: one-cycle tick when the prescaler wraps.
  // --------------------------------------------------------------------------
  assign w_tick = (r_presc == c_PRE_W'(c_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Budget arbiter. Only the current-state lit count is used, so a slot
  // freed this cycle is granted on the following one. A WAIT zone that is
  // about to drop back to IDLE is not eligible, so no grant is wasted.
  // --------------------------------------------------------------------------
  always_comb begin : p_arb
    int                 v_sum;
    logic [c_PTR_W-1:0] v_idx;
    logic               v_found;
    v_sum     = 0;
    v_idx     = '0;
    v_found   = 1'b0;
    w_grant   = '0;
    w_rr_next = r_rr_ptr;
    w_lit_now = '0;
    for (int i = 0; i < int'(N_ZONES); i++) begin
      w_lit_now = w_lit_now + c_LIT_W'(w_lit[i]);
    end
    if (w_lit_now < c_LIT_W'(MAX_ON)) begin
      for (int k = 0; k < int'(N_ZONES); k++) begin
        v_sum = int'(r_rr_ptr) + k;
        if (v_sum >= int'(N_ZONES)) begin
          v_sum = v_sum - int'(N_ZONES);
        end
        v_idx = c_PTR_W'(v_sum);
        if (!v_found && w_elig[v_idx]) begin
          v_found        = 1'b1;
          w_grant[v_idx] = 1'b1;
          w_rr_next      = (v_sum == int'(N_ZONES) - 1) ? '0 : c_PTR_W'(v_sum + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else begin
      r_rr_ptr <= w_rr_next;
    end
  end

  // --------------------------------------------------------------------------
  // Per-zone debounce and occupancy FSM.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < int'(N_ZONES); i++) begin : g_zone
    zone_state_t         r_state;
    zone_state_t         w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;

    pir_debounce #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_tick   (w_tick),
      .i_pir_n  (i_pir_n[i]),
      .o_motion (w_motion[i])
    );

    always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      if (!i_enable) begin
        w_state_nxt = ZS_IDLE;
      end else begin
        case (r_state)
          ZS_IDLE: begin
            if (w_motion[i]) w_state_nxt = ZS_WAIT;
          end
          ZS_WAIT: begin
            if (!w_motion[i])    w_state_nxt = ZS_IDLE;
            else if (w_grant[i]) w_state_nxt = ZS_LIT;
          end
          ZS_LIT: begin
            if (!w_motion[i]) begin
              w_state_nxt = ZS_HOLD;
              w_hold_nxt  = c_HOLD_W'(c_HOLD_TICKS);
            end
          end
          ZS_HOLD: begin
            // Retrigger keeps the budget slot; expiry happens on the tick
            // that sees the counter at 1.
            if (w_motion[i]) begin
              w_state_nxt = ZS_LIT;
            end else if (w_tick) begin
              if (r_hold == c_HOLD_W'(1)) w_state_nxt = ZS_IDLE;
              w_hold_nxt = r_hold - 1'b1;
            end
          end
          default: w_state_nxt = ZS_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= ZS_IDLE;
        r_hold  <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_hold  <= w_hold_nxt;
      end
    end

    assign w_lit[i]     = (r_state == ZS_LIT) || (r_state == ZS_HOLD);
    assign w_elig[i]    = (r_state == ZS_WAIT) && w_motion[i] && i_enable;
    assign o_led_out[i] = w_lit[i];
    assign o_waiting[i] = (r_state == ZS_WAIT);
  end

  assign o_lit_count = w_lit_now;

endmodule
`default_nettype wire

// File: tb/tb_smart_lights_zone_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_smart_lights_zone_ctrl
// Description : Scoreboard bench for smart_lights_zone_ctrl. Stimulus pushes
//               expected output events (value, cycle window, optional exact
//               distance from the previous event) or stability probes; the
//               monitor compares each output change against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smart_lights_zone_ctrl;

  localparam int MAX_ON = 2;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] pir_n   = 4'hF;
  logic       enable  = 1'b1;
  logic [3:0] led;
  logic [3:0] wt;
  logic [2:0] lcnt;

  smart_lights_zone_ctrl #(
    .CLK_FREQ_HZ    (10_000),
    .TICK_HZ        (1000),
    .N_ZONES        (4),
    .MAX_ON         (MAX_ON),
    .HOLD_TIME_SEC  (1),
    .DEBOUNCE_TICKS (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_pir_n     (pir_n),
    .i_enable    (enable),
    .o_led_out   (led),
    .o_waiting   (wt),
    .o_lit_count (lcnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          probe;
    string       name;
    logic [3:0]  led;
    logic [3:0]  wt;
    logic [2:0]  cnt;
    int unsigned lo;
    int unsigned hi;
    int          dprev;
  } exp_t;

  exp_t q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   timeouts = 0;
  bit   done     = 1'b0;

  task automatic push_change(input string nm, input logic [3:0] l, input logic [3:0] w,
                             input logic [2:0] c, input int unsigned lo,
                             input int unsigned hi, input int dp);
    exp_t e;
    e.probe = 1'b0; e.name = nm; e.led = l; e.wt = w; e.cnt = c;
    e.lo = lo; e.hi = hi; e.dprev = dp;
    q.push_back(e);
  endtask

  task automatic push_probe(input string nm, input logic [3:0] l, input logic [3:0] w,
                            input logic [2:0] c);
    exp_t e;
    e.probe = 1'b1; e.name = nm; e.led = l; e.wt = w; e.cnt = c;
    e.lo = 0; e.hi = 0; e.dprev = -1;
    q.push_back(e);
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while (q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        timeouts++;
        q.delete();
      end
    end
  endtask

  task automatic do_reset(input bit was_lit);
    @(negedge clk);
    #2;
    if (was_lit) push_change("reset_clear", 4'b0000, 4'b0000, 3'd0, cyc, cyc, -1);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    drain(5);
  endtask

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  initial begin : p_mon
    logic [10:0] prev;
    logic [10:0] cur;
    exp_t        e;
    int unsigned last_cyc;
    int          tmo_seen;
    prev     = '0;
    last_cyc = 0;
    tmo_seen = 0;
    forever begin
      @(negedge clk or negedge reset_n);
      #1;
      cur = {led, wt, lcnt};
      if (reset_n) begin
        checks++;
        assert (lcnt <= 3'(MAX_ON)) else begin
          $display("FAIL lit_budget: lit_count=%0d above limit %0d at cyc %0d", lcnt, MAX_ON, cyc);
          errors++;
        end
      end
      if (cur !== prev) begin
        if (q.size() == 0 || q[0].probe) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: led=%b wait=%b cnt=%0d at cyc %0d, required no change",
                   led, wt, lcnt, cyc);
        end else begin
          e = q.pop_front();
          checks++;
          if ({led, wt, lcnt} !== {e.led, e.wt, e.cnt}) begin
            errors++;
            $display("FAIL %s: led=%b wait=%b cnt=%0d, required led=%b wait=%b cnt=%0d",
                     e.name, led, wt, lcnt, e.led, e.wt, e.cnt);
          end
          checks++;
          if (cyc < e.lo || cyc > e.hi) begin
            errors++;
            $display("FAIL %s_time: at cyc %0d, required cyc %0d..%0d", e.name, cyc, e.lo, e.hi);
          end
          if (e.dprev >= 0) begin
            checks++;
            if (cyc - last_cyc != e.dprev) begin
              errors++;
              $display("FAIL %s_gap: %0d cycles after previous change, required %0d",
                       e.name, cyc - last_cyc, e.dprev);
            end
          end
        end
        prev     = cur;
        last_cyc = cyc;
      end else if (q.size() != 0 && q[0].probe) begin
        e = q.pop_front();
        checks++;
        if (cur !== {e.led, e.wt, e.cnt}) begin
          errors++;
          $display("FAIL %s: led=%b wait=%b cnt=%0d, required led=%b wait=%b cnt=%0d",
                   e.name, led, wt, lcnt, e.led, e.wt, e.cnt);
        end
      end
      if (timeouts != tmo_seen) begin
        checks++;
        errors++;
        tmo_seen = timeouts;
        $display("FAIL timeout: expected events still pending at cyc %0d, required none", cyc);
      end
      if (done) begin
        checks++;
        if (q.size() != 0) begin
          errors++;
          $display("FAIL leftover: %0d expectations pending, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin : p_watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin : p_stim
    int unsigned s;
    int unsigned s1;

    // Reset state
    #1 reset_n = 1'b0;
    push_probe("reset_state", 4'b0000, 4'b0000, 3'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    drain(5);

    // 1. Single zone: about 32 cycles to light, 1000-tick off-delay
    repeat (7) @(negedge clk);
    s = cyc; pir_n[0] = 1'b0;
    push_change("t1_wait", 4'b0000, 4'b0001, 3'd0, s + 22, s + 36, -1);
    push_change("t1_lit",  4'b0001, 4'b0000, 3'd1, s + 22, s + 37, 1);
    drain(100);
    repeat (470) @(negedge clk);
    push_probe("t1_on", 4'b0001, 4'b0000, 3'd1);
    s = cyc; pir_n[0] = 1'b1;
    push_change("t1_off", 4'b0000, 4'b0000, 3'd0, s + 10020, s + 10036, -1);
    drain(11000);

    // 2. Debounce rejection: 2-tick pulse and sub-tick glitches
    pir_n[1] = 1'b0; repeat (20) @(negedge clk);
    pir_n[1] = 1'b1; repeat (15) @(negedge clk);
    pir_n[1] = 1'b0; repeat (5)  @(negedge clk);
    pir_n[1] = 1'b1; repeat (7)  @(negedge clk);
    pir_n[1] = 1'b0; repeat (3)  @(negedge clk);
    pir_n[1] = 1'b1; repeat (60) @(negedge clk);
    push_probe("t2_quiet", 4'b0000, 4'b0000, 3'd0);
    drain(5);

    // 3. Budget: three zones ask, two are lit
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    s = cyc; pir_n[2:0] = 3'b000;
    push_change("t3_wait", 4'b0000, 4'b0111, 3'd0, s + 22, s + 36, -1);
    push_change("t3_g0",   4'b0001, 4'b0110, 3'd1, s + 23, s + 37, 1);
    push_change("t3_g1",   4'b0011, 4'b0100, 3'd2, s + 24, s + 38, 1);
    drain(100);
    push_probe("t3_budget", 4'b0011, 4'b0100, 3'd2);
    repeat (20) @(negedge clk);
    s = cyc; pir_n[0] = 1'b1;
    push_change("t3_expire", 4'b0010, 4'b0100, 3'd1, s + 10020, s + 10036, -1);
    push_change("t3_g2",     4'b0110, 4'b0000, 3'd2, s + 10021, s + 10037, 1);
    drain(11000);

    // 4. Round-robin order from pointer 0
    pir_n = 4'hF;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    s = cyc; pir_n = 4'b0000;
    push_change("t4_wait", 4'b0000, 4'b1111, 3'd0, s + 22, s + 36, -1);
    push_change("t4_g0",   4'b0001, 4'b1110, 3'd1, s + 23, s + 37, 1);
    push_change("t4_g1",   4'b0011, 4'b1100, 3'd2, s + 24, s + 38, 1);
    drain(100);
    repeat (20) @(negedge clk);
    s = cyc; pir_n[1] = 1'b1;
    push_change("t4_free1", 4'b0001, 4'b1100, 3'd1, s + 10020, s + 10036, -1);
    push_change("t4_g2",    4'b0101, 4'b1000, 3'd2, s + 10021, s + 10037, 1);
    drain(11000);
    repeat (20) @(negedge clk);
    s = cyc; pir_n[2] = 1'b1;
    push_change("t4_free2", 4'b0001, 4'b1000, 3'd1, s + 10020, s + 10036, -1);
    push_change("t4_g3",    4'b1001, 4'b0000, 3'd2, s + 10021, s + 10037, 1);
    drain(11000);

    // 5. Retrigger during hold, then a full hold after final release
    pir_n = 4'hF;
    do_reset(1'b1);
    repeat (5) @(negedge clk);
    s = cyc; pir_n[0] = 1'b0;
    push_change("t5_wait", 4'b0000, 4'b0001, 3'd0, s + 22, s + 36, -1);
    push_change("t5_lit",  4'b0001, 4'b0000, 3'd1, s + 22, s + 37, 1);
    drain(100);
    repeat (100) @(negedge clk);
    s1 = cyc; pir_n[0] = 1'b1;
    repeat (5030) @(negedge clk);
    push_probe("t5_mid_hold", 4'b0001, 4'b0000, 3'd1);
    pir_n[0] = 1'b0;
    repeat (200) @(negedge clk);
    push_probe("t5_retrig", 4'b0001, 4'b0000, 3'd1);
    drain(5);
    s = cyc; pir_n[0] = 1'b1;
    push_change("t5_full_hold", 4'b0000, 4'b0000, 3'd0, s + 10020, s + 10036, -1);
    drain(11000);
    if (cyc - s1 < 15000) begin
      repeat (1) @(negedge clk);
    end

    // 6. Enable and asynchronous reset
    do_reset(1'b0);
    repeat (6) @(negedge clk);
    s = cyc; pir_n[1:0] = 2'b00;
    push_change("t6_wait", 4'b0000, 4'b0011, 3'd0, s + 22, s + 36, -1);
    push_change("t6_g0",   4'b0001, 4'b0010, 3'd1, s + 23, s + 37, 1);
    push_change("t6_g1",   4'b0011, 4'b0000, 3'd2, s + 24, s + 38, 1);
    drain(100);
    repeat (10) @(negedge clk);
    s = cyc; enable = 1'b0;
    push_change("t6_disable", 4'b0000, 4'b0000, 3'd0, s + 1, s + 1, -1);
    drain(10);
    repeat (10) @(negedge clk);
    s = cyc; enable = 1'b1;
    push_change("t6_rewait", 4'b0000, 4'b0011, 3'd0, s + 1, s + 1, -1);
    push_change("t6_relit0", 4'b0001, 4'b0010, 3'd1, s + 2, s + 2, 1);
    push_change("t6_relit1", 4'b0011, 4'b0000, 3'd2, s + 3, s + 3, 1);
    drain(10);
    repeat (10) @(negedge clk);
    pir_n[0] = 1'b1;
    repeat (100) @(negedge clk);
    push_probe("t6_in_hold", 4'b0011, 4'b0000, 3'd2);
    #2;
    s = cyc;
    push_change("t6_async_rst", 4'b0000, 4'b0000, 3'd0, s, s, -1);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    s = cyc;
    push_change("t6_fresh_wait", 4'b0000, 4'b0010, 3'd0, s + 22, s + 36, -1);
    push_change("t6_fresh_lit",  4'b0010, 4'b0000, 3'd1, s + 22, s + 37, 1);
    drain(100);

    repeat (2) @(negedge clk);
    done = 1'b1;
  end

endmodule
`default_nettype wire
